// File: rtl/alu_pkg.sv
// alu_pkg: shared state encoding, opcode/fcode values and flag bit positions for the ALU issue front-end
package alu_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, DRIVE = 2'd1, RESP = 2'd2} state_t;
  localparam logic [2:0] OPC_REG    = 3'd0;
  localparam logic [2:0] OPC_IMM    = 3'd1;
  localparam logic [3:0] FCODE_ADD  = 4'h0;
  localparam logic [3:0] FCODE_FCLR = 4'hF;
  localparam int FLAG_C = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_S = 1;
  localparam int FLAG_O = 0;
endpackage

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: registers one decoded op into the ALU, captures its result and flags, hands it to writeback
// Optional feature: define STICKY_OVF_EN to make the overflow flag sticky until a flag-clear op.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int         DATA_W  = 32,
  parameter int         IMM_W   = 16,
  parameter logic [2:0] IMM_OPC = OPC_IMM
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_opcode,
  input  logic [3:0]        req_fcode,
  input  logic [DATA_W-1:0] req_rs,
  input  logic [DATA_W-1:0] req_rt,
  input  logic [IMM_W-1:0]  req_imm,
  output logic [DATA_W-1:0] alu_inp1,
  output logic [DATA_W-1:0] alu_inp2,
  output logic [2:0]        alu_opcode,
  output logic [3:0]        alu_fcode,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [DATA_W-1:0] alu_ext_out,
  input  logic              alu_c,
  input  logic              alu_z,
  input  logic              alu_s,
  input  logic              alu_o,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic [DATA_W-1:0] res_ext,
  output logic [3:0]        flags
);
  state_t            state_q, state_d;
  logic [DATA_W-1:0] inp1_q, inp2_q, data_q, ext_q;
  logic [2:0]        opc_q;
  logic [3:0]        fc_q, flags_q, flags_d;
  logic              accept, capture, upd_flags, ovf;

  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;

  always_comb begin
    state_d = flush               ? IDLE :
              (state_q == IDLE)   ? (req_valid ? DRIVE : IDLE) :
              (state_q == DRIVE)  ? RESP :
              res_ready           ? IDLE : RESP;
  end

  always_comb begin
    req_ready = (state_q == IDLE);
    res_valid = (state_q == RESP);
  end

  assign accept    = (state_q == IDLE) && req_valid && !flush;
  assign capture   = (state_q == DRIVE) && !flush;
  assign upd_flags = capture && (opc_q == OPC_REG || opc_q == IMM_OPC);

`ifdef STICKY_OVF_EN
  // The flag-clear op is the only way, short of reset, to drop a latched overflow.
  assign ovf = (opc_q == OPC_REG && fc_q == FCODE_FCLR) ? 1'b0 : (flags_q[FLAG_O] | alu_o);
`else
  assign ovf = alu_o;
`endif

  always_comb begin
    flags_d         = flags_q;
    flags_d[FLAG_C] = alu_c;
    flags_d[FLAG_Z] = alu_z;
    flags_d[FLAG_S] = alu_s;
    flags_d[FLAG_O] = ovf;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      opc_q   <= '0;
      fc_q    <= '0;
      inp1_q  <= '0;
      inp2_q  <= '0;
      data_q  <= '0;
      ext_q   <= '0;
      flags_q <= '0;
    end else begin
      if (accept) begin
        opc_q  <= req_opcode;
        fc_q   <= req_fcode;
        inp1_q <= req_rs;
        inp2_q <= (req_opcode == IMM_OPC) ? {{(DATA_W-IMM_W){req_imm[IMM_W-1]}}, req_imm} : req_rt;
      end
      if (capture) begin
        data_q <= alu_out;
        ext_q  <= alu_ext_out;
      end
      if (upd_flags) flags_q <= flags_d;
    end

  assign alu_inp1   = inp1_q;
  assign alu_inp2   = inp2_q;
  assign alu_opcode = opc_q;
  assign alu_fcode  = fc_q;
  assign res_data   = data_q;
  assign res_ext    = ext_q;
  assign flags      = flags_q;
endmodule
